// File: rtl/nn_layer_sequencer.sv
// Fully-connected layer sequencer: walks neurons and inputs, issues
// memory reads, and strobes the MAC, activation and output-write stages.
module nn_layer_sequencer #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 4,
    parameter int IN_AW       = 3,
    parameter int NEU_AW      = 2,
    parameter int W_AW        = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              ready,
    output logic              done,
    output logic              rd_en,
    output logic [W_AW-1:0]   w_addr,
    output logic [IN_AW-1:0]  x_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              act_en,
    output logic              out_we,
    output logic [NEU_AW-1:0] out_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IN_AW-1:0]  LAST_I = IN_AW'(NUM_INPUTS - 1);
    localparam logic [NEU_AW-1:0] LAST_N = NEU_AW'(NUM_NEURONS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [IN_AW-1:0]    r_i;
    logic [IN_AW-1:0]    w_i_nxt;
    logic [NEU_AW-1:0]   r_neu;
    logic [NEU_AW-1:0]   w_neu_nxt;
    logic                w_issue;
    logic [W_AW-1:0]     w_waddr;

    logic                r_ready;
    logic                r_done;
    logic                r_rd_en;
    logic [W_AW-1:0]     r_w_addr;
    logic [IN_AW-1:0]    r_x_addr;
    logic                r_mac_clr;
    logic                r_mac_en;
    logic                r_act_en;
    logic                r_out_we;
    logic [NEU_AW-1:0]   r_out_addr;

    assign w_waddr = W_AW'(int'(r_neu) * NUM_INPUTS + int'(r_i));

    // Next state, counter updates and read-issue decision for the coming cycle
    always_comb begin
        w_next    = r_state;
        w_i_nxt   = r_i;
        w_neu_nxt = r_neu;
        w_issue   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next    = S_CLEAR;
                    w_neu_nxt = '0;
                    w_i_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_next  = S_RUN;
                w_issue = 1'b1;
            end
            S_RUN: begin
                if (r_rd_en && (r_x_addr == LAST_I)) begin
                    w_next = S_DRAIN;
                end else if (!stall) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: w_next = S_ACT;
            S_ACT:   w_next = S_WRITE;
            S_WRITE: begin
                if (r_neu == LAST_N) begin
                    w_next = S_DONE;
                end else begin
                    w_next    = S_CLEAR;
                    w_neu_nxt = r_neu + 1'b1;
                    w_i_nxt   = '0;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_issue && (r_i != LAST_I)) begin
            w_i_nxt = r_i + 1'b1;
        end
    end

    // State, counters and registered strobes; mac_en trails rd_en by the read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_neu      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_w_addr   <= '0;
            r_x_addr   <= '0;
            r_mac_clr  <= 1'b0;
            r_mac_en   <= 1'b0;
            r_act_en   <= 1'b0;
            r_out_we   <= 1'b0;
            r_out_addr <= '0;
        end else begin
            r_state   <= w_next;
            r_i       <= w_i_nxt;
            r_neu     <= w_neu_nxt;
            r_ready   <= (w_next == S_IDLE);
            r_done    <= (w_next == S_DONE);
            r_mac_clr <= (w_next == S_CLEAR);
            r_act_en  <= (w_next == S_ACT);
            r_out_we  <= (w_next == S_WRITE);
            r_rd_en   <= w_issue;
            r_mac_en  <= r_rd_en;
            if (w_issue) begin
                r_w_addr <= w_waddr;
                r_x_addr <= r_i;
            end
            if (w_next == S_WRITE) begin
                r_out_addr <= r_neu;
            end
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign rd_en    = r_rd_en;
    assign w_addr   = r_w_addr;
    assign x_addr   = r_x_addr;
    assign mac_clr  = r_mac_clr;
    assign mac_en   = r_mac_en;
    assign act_en   = r_act_en;
    assign out_we   = r_out_we;
    assign out_addr = r_out_addr;

endmodule
